// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - machine-mode timer-interrupt entry and mret return sequencer
//
// Purpose:
//   Sits beside the EX stage of the 3-stage RV32I pipeline. It decides when a
//   pending timer interrupt is taken or an mret retires. It then redirects the
//   PC, squashes IF/ID and pulses the CSR-file update strobes. After each
//   redirect it holds off for HOLD_CYCLES quiet cycles.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   timer_irq, mstatus_mie,
//   mie_mtie                  interrupt request and its two enables
//   ex_valid, ex_redirect,
//   is_mret, ex_pc            EX-stage instruction status and PC
//   mtvec, mepc               trap vector and exception PC CSRs
//   pc_redir_en, pc_redir     one-cycle PC load pulse and its target
//   flush                     one-cycle IF/ID squash pulse
//   epc_wr, epc_val           mepc write pulse and value
//   cause_wr, cause_val       mcause write pulse and value
//   mie_clr, mie_restore      mstatus MIE/MPIE update pulses
//   busy                      sequencer is not idle
//   irq_count                 saturating count of taken interrupts
module trap_sequencer #(
  parameter int XLEN        = 32,
  parameter int HOLD_CYCLES = 2,
  parameter int CAUSE_CODE  = 7,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timer_irq,
  input  logic             mstatus_mie,
  input  logic             mie_mtie,
  input  logic             ex_valid,
  input  logic             ex_redirect,
  input  logic             is_mret,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  mtvec,
  input  logic [XLEN-1:0]  mepc,
  output logic             pc_redir_en,
  output logic [XLEN-1:0]  pc_redir,
  output logic             flush,
  output logic             epc_wr,
  output logic [XLEN-1:0]  epc_val,
  output logic             cause_wr,
  output logic [XLEN-1:0]  cause_val,
  output logic             mie_clr,
  output logic             mie_restore,
  output logic             busy,
  output logic [CNT_W-1:0] irq_count
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [XLEN-1:0] CAUSE_VAL = {1'b1, (XLEN-1)'(CAUSE_CODE)};
  localparam logic [XLEN-1:0] VEC_OFFSET = XLEN'(CAUSE_CODE) << 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TAKE,
    S_RET,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;

  logic              pc_redir_en_q, pc_redir_en_d;
  logic [XLEN-1:0]   pc_redir_q, pc_redir_d;
  logic              flush_q, flush_d;
  logic              epc_wr_q, epc_wr_d;
  logic [XLEN-1:0]   epc_val_q, epc_val_d;
  logic              cause_wr_q, cause_wr_d;
  logic [XLEN-1:0]   cause_val_q, cause_val_d;
  logic              mie_clr_q, mie_clr_d;
  logic              mie_restore_q, mie_restore_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  irq_count_q, irq_count_d;

  logic              pend;
  logic [XLEN-1:0]   trap_base;
  logic [XLEN-1:0]   trap_target;
  logic              unused_mepc_lsbs;

  assign pend      = timer_irq & mie_mtie & mstatus_mie;
  assign trap_base = {mtvec[XLEN-1:2], 2'b00};
  // Only mode 01 vectors; the reserved modes 10/11 fall back to direct.
  assign trap_target = (mtvec[1:0] == 2'b01) ? trap_base + VEC_OFFSET : trap_base;
  assign unused_mepc_lsbs = ^mepc[1:0];

  // State register (outputs are registered alongside it)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      hold_cnt_q    <= '0;
      pc_redir_en_q <= 1'b0;
      pc_redir_q    <= '0;
      flush_q       <= 1'b0;
      epc_wr_q      <= 1'b0;
      epc_val_q     <= '0;
      cause_wr_q    <= 1'b0;
      cause_val_q   <= '0;
      mie_clr_q     <= 1'b0;
      mie_restore_q <= 1'b0;
      busy_q        <= 1'b0;
      irq_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      pc_redir_en_q <= pc_redir_en_d;
      pc_redir_q    <= pc_redir_d;
      flush_q       <= flush_d;
      epc_wr_q      <= epc_wr_d;
      epc_val_q     <= epc_val_d;
      cause_wr_q    <= cause_wr_d;
      cause_val_q   <= cause_val_d;
      mie_clr_q     <= mie_clr_d;
      mie_restore_q <= mie_restore_d;
      busy_q        <= busy_d;
      irq_count_q   <= irq_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        // mret has priority; a coincident interrupt is re-evaluated after HOLD.
        if (ex_valid && is_mret) begin
          state_d = S_RET;
        end else if (pend && ex_valid && !ex_redirect) begin
          state_d = S_TAKE;
        end
      end
      S_TAKE, S_RET: begin
        state_d    = S_HOLD;
        hold_cnt_d = HW'(HOLD_CYCLES - 1);
      end
      S_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: computed from the upcoming state so the registered pulses
  // line up with the TAKE/RET cycle itself.
  always_comb begin
    pc_redir_en_d = 1'b0;
    flush_d       = 1'b0;
    epc_wr_d      = 1'b0;
    cause_wr_d    = 1'b0;
    mie_clr_d     = 1'b0;
    mie_restore_d = 1'b0;
    pc_redir_d    = pc_redir_q;
    epc_val_d     = epc_val_q;
    cause_val_d   = cause_val_q;
    irq_count_d   = irq_count_q;
    busy_d        = (state_d != S_IDLE);
    if (state_d == S_TAKE) begin
      pc_redir_en_d = 1'b1;
      flush_d       = 1'b1;
      epc_wr_d      = 1'b1;
      cause_wr_d    = 1'b1;
      mie_clr_d     = 1'b1;
      pc_redir_d    = trap_target;
      epc_val_d     = ex_pc + XLEN'(4);
      cause_val_d   = CAUSE_VAL;
      irq_count_d   = (irq_count_q == '1) ? irq_count_q : irq_count_q + CNT_W'(1);
    end else if (state_d == S_RET) begin
      pc_redir_en_d = 1'b1;
      flush_d       = 1'b1;
      mie_restore_d = 1'b1;
      pc_redir_d    = {mepc[XLEN-1:2], 2'b00};
    end
  end

  assign pc_redir_en = pc_redir_en_q;
  assign pc_redir    = pc_redir_q;
  assign flush       = flush_q;
  assign epc_wr      = epc_wr_q;
  assign epc_val     = epc_val_q;
  assign cause_wr    = cause_wr_q;
  assign cause_val   = cause_val_q;
  assign mie_clr     = mie_clr_q;
  assign mie_restore = mie_restore_q;
  assign busy        = busy_q;
  assign irq_count   = irq_count_q;

endmodule
